// File: rtl/delay_meas_ctrl_pkg.sv
// Shared types and width helpers for the
// delay-measurement launch/capture block.
package delay_meas_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_LAUNCH,
    ST_WAIT,
    ST_DONE
  } state_t;

  // Accumulator holds NUM_TRIALS samples of CNT_W bits each.
  function automatic int acc_w(input int cnt_w, input int n);
    return cnt_w + $clog2(n);
  endfunction

  // Trial counter must be able to represent NUM_TRIALS itself.
  function automatic int trial_w(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/sync_ff_chain.sv
// Multi-stage flop synchroniser for one
// asynchronous input bit, reset to 0.
module sync_ff_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  // Shift the async bit through the chain.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/delay_meas_ctrl.sv
// Launches edges into a delay path, times the
// returning echo and averages over several trials.
module delay_meas_ctrl
  import delay_meas_ctrl_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter int TIMEOUT     = 200,
  parameter int NUM_TRIALS  = 4,
  parameter int SYNC_STAGES = 2,
  parameter int SETTLE      = 4,
  parameter int INVERT      = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             start,
  input  logic             echo_in,
  output logic             launch_out,
  output logic             busy,
  output logic             done,
  output logic             err_timeout,
  output logic             err_stuck,
  output logic [CNT_W-1:0] result,
  output logic [CNT_W-1:0] last_sample
);

  localparam int ACC_W   = acc_w(CNT_W, NUM_TRIALS);
  localparam int TRIAL_W = trial_w(NUM_TRIALS);
  localparam int SHIFT   = $clog2(NUM_TRIALS);
  localparam int SET_W   = $clog2(SETTLE + 1);

  localparam logic [CNT_W-1:0]   TO_C  = CNT_W'(TIMEOUT);
  localparam logic [TRIAL_W-1:0] NT_C  = TRIAL_W'(NUM_TRIALS);
  localparam logic [SET_W-1:0]   SL_C  = SET_W'(SETTLE - 1);
  localparam logic               INV_C = (INVERT != 0);

  state_t r_state;
  state_t w_next;

  logic               r_launch;
  logic               r_busy;
  logic               r_err_to;
  logic               r_err_st;
  logic [CNT_W-1:0]   r_result;
  logic [CNT_W-1:0]   r_last;
  logic [CNT_W-1:0]   r_cnt;
  logic [TRIAL_W-1:0] r_trial;
  logic [ACC_W-1:0]   r_acc;
  logic [SET_W-1:0]   r_settle;

  logic               w_echo_s;
  logic               w_match;
  logic               w_settle_end;
  logic               w_timeout;
  logic               w_last_trial;
  logic               w_abort;
  logic               w_done;
  logic [TRIAL_W-1:0] w_trial_nx;

  sync_ff_chain #(
    .STAGES (SYNC_STAGES)
  ) u_echo_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (echo_in),
    .o_q   (w_echo_s)
  );

  // Echo has reached the level implied by the current launch level.
  assign w_match      = (w_echo_s == (r_launch ^ INV_C));
  assign w_settle_end = (r_settle == SL_C);
  assign w_timeout    = (r_cnt == TO_C);
  assign w_trial_nx   = r_trial + TRIAL_W'(1);
  assign w_last_trial = (w_trial_nx == NT_C);
  assign w_abort      = (r_state != ST_IDLE) && !ena;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode; a dropped enable wins over everything.
  always_comb begin
    w_next = r_state;
    if (w_abort) begin
      w_next = ST_IDLE;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (start && ena) w_next = ST_SETTLE;
        end
        ST_SETTLE: begin
          if (w_settle_end) begin
            w_next = w_match ? ST_LAUNCH : ST_DONE;
          end
        end
        ST_LAUNCH: begin
          w_next = ST_WAIT;
        end
        ST_WAIT: begin
          if (w_match) begin
            w_next = w_last_trial ? ST_DONE : ST_LAUNCH;
          end else if (w_timeout) begin
            w_next = ST_DONE;
          end
        end
        ST_DONE: begin
          w_next = ST_IDLE;
        end
        default: begin
          w_next = ST_IDLE;
        end
      endcase
    end
  end

  // Moore outputs decoded from the state.
  always_comb begin
    w_done = (r_state == ST_DONE);
  end

  // Datapath: counters, accumulator, flags and launch pin.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_launch <= 1'b0;
      r_busy   <= 1'b0;
      r_err_to <= 1'b0;
      r_err_st <= 1'b0;
      r_result <= '0;
      r_last   <= '0;
      r_cnt    <= '0;
      r_trial  <= '0;
      r_acc    <= '0;
      r_settle <= '0;
    end else if (w_abort) begin
      r_busy <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (start && ena) begin
            r_busy   <= 1'b1;
            r_err_to <= 1'b0;
            r_err_st <= 1'b0;
            r_trial  <= '0;
            r_acc    <= '0;
            r_settle <= '0;
          end
        end
        ST_SETTLE: begin
          if (w_settle_end) begin
            if (!w_match) r_err_st <= 1'b1;
          end else begin
            r_settle <= r_settle + SET_W'(1);
          end
        end
        ST_LAUNCH: begin
          r_launch <= ~r_launch;
          r_cnt    <= '0;
        end
        ST_WAIT: begin
          if (w_match) begin
            r_acc   <= r_acc + ACC_W'(r_cnt);
            r_last  <= r_cnt;
            r_trial <= w_trial_nx;
          end else if (w_timeout) begin
            r_err_to <= 1'b1;
            r_last   <= TO_C;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_DONE: begin
          r_busy <= 1'b0;
          if (!r_err_to && !r_err_st) begin
            r_result <= CNT_W'(r_acc >> SHIFT);
          end
        end
        default: begin
          r_busy <= 1'b0;
        end
      endcase
    end
  end

  assign launch_out  = r_launch;
  assign busy        = r_busy;
  assign done        = w_done;
  assign err_timeout = r_err_to;
  assign err_stuck   = r_err_st;
  assign result      = r_result;
  assign last_sample = r_last;

endmodule

// File: tb/tb_delay_meas_ctrl.sv
// Directed bench for delay_meas_ctrl with a
// behavioural delay-path model on the echo pin.
module tb_delay_meas_ctrl;

  typedef struct {
    logic [1:0] mode;
    int         d0;
    int         d1;
    int         d2;
    int         d3;
    int         res;
    int         last;
    int         eto;
    int         est;
    int         tog;
    int         lend;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic       start;
  logic       echo_in;
  logic       launch_out;
  logic       busy;
  logic       done;
  logic       err_timeout;
  logic       err_stuck;
  logic [7:0] result;
  logic [7:0] last_sample;

  // mode 0: zero-delay inverter, 1: modelled delay,
  // 2: tied low, 3: frozen at fz
  logic [1:0] mode = 2'd0;
  logic       fz = 1'b0;
  logic       echo_r = 1'b1;
  logic       last_l = 1'b0;
  int         cd = 0;
  int         tog_i = 0;
  int         dtab [4] = '{1, 1, 1, 1};

  int n_chk = 0;
  int n_fail = 0;
  int done_cnt = 0;
  vec_t vt [7];

  delay_meas_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .start       (start),
    .echo_in     (echo_in),
    .launch_out  (launch_out),
    .busy        (busy),
    .done        (done),
    .err_timeout (err_timeout),
    .err_stuck   (err_stuck),
    .result      (result),
    .last_sample (last_sample)
  );

  always #5 clk = ~clk;

  // Delay path: echo follows ~launch after dtab[k] edges
  always @(posedge clk) begin
    last_l <= launch_out;
    if (launch_out != last_l) begin
      if (dtab[tog_i % 4] <= 1) echo_r <= ~launch_out;
      else cd <= dtab[tog_i % 4] - 1;
      tog_i <= tog_i + 1;
    end else if (cd != 0) begin
      cd <= cd - 1;
      if (cd == 1) echo_r <= ~launch_out;
    end
  end

  assign echo_in = (mode == 2'd0) ? ~launch_out :
                   (mode == 2'd1) ? echo_r :
                   (mode == 2'd2) ? 1'b0 : fz;

  always @(negedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string nm, input int act,
                     input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int  tog;
    int  d0;
    bit  got;
    bit  busy_ok;
    logic prev;
    mode    = v.mode;
    dtab[0] = v.d0;
    dtab[1] = v.d1;
    dtab[2] = v.d2;
    dtab[3] = v.d3;
    fz      = ~launch_out;
    tog     = 0;
    got     = 0;
    busy_ok = 1;
    d0      = done_cnt;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    prev = launch_out;
    for (int c = 0; c < 3000 && !got; c++) begin
      if (launch_out != prev) tog++;
      prev = launch_out;
      if (done) got = 1;
      else begin
        if (!busy) busy_ok = 0;
        @(negedge clk);
      end
    end
    chk($sformatf("v%0d_done_seen", idx), int'(got), 1);
    @(negedge clk);
    chk($sformatf("v%0d_busy_hi", idx), int'(busy_ok), 1);
    chk($sformatf("v%0d_busy_lo", idx), int'(busy), 0);
    chk($sformatf("v%0d_result", idx), int'(result), v.res);
    chk($sformatf("v%0d_last", idx),
        int'(last_sample), v.last);
    chk($sformatf("v%0d_err_to", idx),
        int'(err_timeout), v.eto);
    chk($sformatf("v%0d_err_st", idx),
        int'(err_stuck), v.est);
    chk($sformatf("v%0d_toggles", idx), tog, v.tog);
    chk($sformatf("v%0d_launch", idx),
        int'(launch_out), v.lend);
    repeat (3) @(negedge clk);
    chk($sformatf("v%0d_done_once", idx),
        done_cnt - d0, 1);
  endtask

  initial begin
    vt[0] = '{2'd0, 1, 1, 1, 1, 2, 2, 0, 0, 4, 0};
    vt[1] = '{2'd1, 5, 5, 5, 5, 7, 7, 0, 0, 4, 0};
    vt[2] = '{2'd1, 1, 3, 1, 4, 4, 6, 0, 0, 4, 0};
    vt[3] = '{2'd2, 1, 1, 1, 1, 4, 6, 0, 1, 0, 0};
    vt[4] = '{2'd1, 2, 2, 2, 2, 4, 4, 0, 0, 4, 0};
    vt[5] = '{2'd1, 198, 198, 198, 198,
              200, 200, 0, 0, 4, 0};
    vt[6] = '{2'd3, 1, 1, 1, 1, 200, 200, 1, 0, 1, 1};

    rst_n = 1'b0;
    ena   = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_launch", int'(launch_out), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err_to", int'(err_timeout), 0);
    chk("rst_err_st", int'(err_stuck), 0);
    chk("rst_result", int'(result), 0);
    chk("rst_last", int'(last_sample), 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    for (int i = 0; i < 7; i++) run_vec(vt[i], i);

    // ena dropped while waiting for an echo
    begin
      int  d0;
      bit  moved;
      mode    = 2'd1;
      dtab    = '{10, 10, 10, 10};
      repeat (4) @(negedge clk);
      d0 = done_cnt;
      moved = 0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int c = 0; c < 40 && !moved; c++) begin
        @(negedge clk);
        if (launch_out == 1'b0) moved = 1;
      end
      chk("ena_launch_moved", int'(moved), 1);
      repeat (3) @(negedge clk);
      chk("ena_busy_before", int'(busy), 1);
      ena = 1'b0;
      @(negedge clk);
      chk("ena_busy", int'(busy), 0);
      chk("ena_launch_kept", int'(launch_out), 0);
      chk("ena_err_to", int'(err_timeout), 0);
      chk("ena_result", int'(result), 200);
      ena = 1'b1;
      repeat (3) @(negedge clk);
      chk("ena_idle", int'(busy), 0);
      chk("ena_no_done", done_cnt - d0, 0);
    end

    // reset asserted in the middle of a run
    begin
      int d0;
      mode = 2'd0;
      repeat (15) @(negedge clk);
      d0 = done_cnt;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (7) @(negedge clk);
      chk("mid_busy_before", int'(busy), 1);
      rst_n = 1'b0;
      @(negedge clk);
      chk("mid_rst_busy", int'(busy), 0);
      chk("mid_rst_done", int'(done), 0);
      chk("mid_rst_launch", int'(launch_out), 0);
      chk("mid_rst_result", int'(result), 0);
      chk("mid_rst_last", int'(last_sample), 0);
      chk("mid_rst_err_to", int'(err_timeout), 0);
      chk("mid_rst_err_st", int'(err_stuck), 0);
      chk("mid_no_done", done_cnt - d0, 0);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      run_vec(vt[0], 7);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/delay_meas_ctrl.md
Name: delay_meas_ctrl

Overview:
- Launch/capture end of the delay-measurement path.
- Toggles a launch pin that feeds the on-chip inverting delay path under test, synchronises the returning echo, and counts clock edges until the echo's new level is seen.
- Repeats NUM_TRIALS times and reports the averaged edge count, last sample, and error flags.
- Sits between the tile's I/O wrapper (start/ena/result pins) and the delay element.

Parameters:
- CNT_W, 8: width of per-trial counter and result.
- TIMEOUT, 200: max edges per trial before abort (must be < 2^CNT_W).
- NUM_TRIALS, 4: trials per measurement; power of two, ≥1.
- SYNC_STAGES, 2: echo synchroniser depth, ≥2.
- SETTLE, 4: idle-level settle cycles before the first launch.
- INVERT, 1: 1 means echo = ~launch at steady state; 0 means echo = launch.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- ena  in  1  tile enable; low aborts to IDLE
- start  in  1  begin measurement; sampled in IDLE only
- echo_in  in  1  asynchronous return from delay path
- launch_out  out  1  drive into delay path
- busy  out  1  measurement in progress
- done  out  1  one-cycle pulse at measurement end (success or error)
- err_timeout  out  1  sticky: a trial hit TIMEOUT
- err_stuck  out  1  sticky: echo not at expected idle level after SETTLE
- result  out  CNT_W  averaged sample count
- last_sample  out  CNT_W  most recent trial's count

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - All outputs 0; FSM=IDLE; synchroniser flops 0; counters and accumulator 0.
- Synchronised echo: echo_s is the last synchroniser stage.
  - Expected level is exp = launch_out ^ INVERT.
- States:
  - IDLE → SETTLE when start=1 and ena=1. On that edge: busy←1, err flags←0, trial←0, acc←0, settle_cnt←0. result and last_sample hold their previous values until updated.
  - SETTLE: launch_out is unchanged and settle_cnt increments each edge. After SETTLE edges:
    - If echo_s ≠ exp: err_stuck←1 → DONE.
    - Otherwise → LAUNCH.
  - LAUNCH: one edge. launch_out←~launch_out, cnt←0 → WAIT.
  - WAIT: cnt increments each edge.
    - Sample = number of rising edges after the toggle edge, up to and including the edge where echo_s first equals exp (the new level).
    - On match: acc←acc+sample, last_sample←sample, trial←trial+1. If trial+1 = NUM_TRIALS → DONE; else → LAUNCH.
    - If cnt reaches TIMEOUT without a match: err_timeout←1, last_sample←TIMEOUT → DONE.
  - DONE: one edge. done=1, busy←0. On success only: result←acc >> log2(NUM_TRIALS), truncating. → IDLE.
- Launch alternates polarity each trial. No re-settle between trials; the previous match proves the level.
- Latency: a zero-delay loopback yields sample = SYNC_STAGES. No correction is subtracted.
- Accumulator width: CNT_W + log2(NUM_TRIALS). It cannot overflow because each sample is ≤ TIMEOUT.
- start while busy: ignored. start held high: one measurement per IDLE entry.
- ena low in any non-IDLE state: next edge → IDLE, busy←0, no done pulse, flags unchanged. launch_out keeps its current level.
- Echo glitch reverting before echo_s match: not counted; timing continues.

Decomposition:
- Shared package:
  - state enum (IDLE, SETTLE, LAUNCH, WAIT, DONE);
  - ACC_W and TRIAL_W derived-width functions.
- Sub-module: sync_ff_chain (SYNC_STAGES, reset-to-0), instantiated once for echo_in.

Test Plan:
- Zero-delay inverter loopback, INVERT=1, start pulse → 4 trials each sample=2; result=2, last_sample=2, done pulse once, errors 0, busy high throughout.
- Loopback delayed by 5 cycles in the testbench → sample=7 each; result=7; launch_out toggles 4 times, ending at 0.
- Alternating samples 3,5,3,6 via testbench delay → result=(17>>2)=4, last_sample=6.
- echo_in tied 0 with INVERT=1 → err_stuck=1 after SETTLE, done pulse, result unchanged from prior value, launch_out never toggles.
- Echo stuck at pre-toggle level after first launch → err_timeout=1 at cnt=200, last_sample=200, done pulse, busy low.
- ena dropped during WAIT, then rst_n low mid-run → IDLE with no done pulse; reset clears all outputs to 0; a following start completes normally.
